trig_sequencer: RTL and testbench

- UART-command-driven trigger controller for the CW312 A7 side-channel target board.
- Consumes bytes from a UART receiver over a valid/ready interface and keeps the programmed delay and width.
- Once armed, it waits for a start edge from the target GPIO, counts a programmable delay, then drives o_trigger for a programmable width.
- Sits between the UART RX deserialiser and the board trigger/LED pins. It replaces the static trigger and LED assignments in the board top.

---
 rtl/trig_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_trig_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/trig_sequencer.sv
// trig_sequencer: UART-command trigger controller (delay, then pulse).
// Define TRIG_SEQ_AUTOREARM_EN to re-arm after every completed pulse.
module trig_sequencer #(
  parameter int DELAY_W = 16,
  parameter int WIDTH_W = 8
) (
  input  logic       i_clk_hs2,
  input  logic       i_reset_n,
  input  logic       i_cmd_valid,
  input  logic [7:0] i_cmd_data,
  output logic       o_cmd_ready,
  input  logic       i_start,
  output logic       o_trigger,
  output logic       o_busy,
  output logic       o_done,
  output logic [2:0] o_led
);

  localparam int HI_W = DELAY_W - 8;

  typedef enum logic [1:0] {
    P_IDLE,
    P_DHI,
    P_DLO,
    P_WID
  } pst_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_PULSE
  } sst_e;

  pst_e               pst_q, pst_d;
  sst_e               sst_q, sst_d;
  logic [DELAY_W-1:0] delay_q, delay_d;
  logic [WIDTH_W-1:0] width_q, width_d;
  logic [DELAY_W-1:0] dcnt_q, dcnt_d;
  logic [WIDTH_W-1:0] wcnt_q, wcnt_d;
  logic               armed_q, armed_d;
  logic               sticky_q, sticky_d;
  logic               done_q, done_d;
  logic               trig_q, trig_d;
  logic               busy_q, busy_d;
  logic               rdy_q;
  logic               s1_q, s2_q, s3_q;
  logic               edge_q;

  logic               accept;
  logic               arm_cmd;
  logic               cancel_cmd;
  logic [WIDTH_W-1:0] wbyte;

  assign accept = i_cmd_valid & rdy_q;
  assign wbyte  = WIDTH_W'(i_cmd_data);

  // Command parser: data bytes are literal, opcodes only in P_IDLE
  always_comb begin
    pst_d      = pst_q;
    delay_d    = delay_q;
    width_d    = width_q;
    arm_cmd    = 1'b0;
    cancel_cmd = 1'b0;
    if (accept) begin
      unique case (pst_q)
        P_IDLE: begin
          unique case (i_cmd_data)
            8'h44:   pst_d = P_DHI;
            8'h57:   pst_d = P_WID;
            8'h41:   arm_cmd = 1'b1;
            8'h43:   cancel_cmd = 1'b1;
            default: pst_d = P_IDLE;
          endcase
        end
        P_DHI: begin
          delay_d[DELAY_W-1:8] = HI_W'(i_cmd_data);
          pst_d = P_DLO;
        end
        P_DLO: begin
          delay_d[7:0] = i_cmd_data;
          pst_d = P_IDLE;
        end
        P_WID: begin
          if (wbyte == '0) begin
            width_d = WIDTH_W'(1);
          end else begin
            width_d = wbyte;
          end
          pst_d = P_IDLE;
        end
        default: pst_d = P_IDLE;
      endcase
    end
  end

  // Counters load at sequence start so config writes only affect later runs
  always_comb begin
    sst_d    = sst_q;
    dcnt_d   = dcnt_q;
    wcnt_d   = wcnt_q;
    armed_d  = armed_q;
    sticky_d = sticky_q;
    done_d   = 1'b0;
    unique case (sst_q)
      S_IDLE: begin
        if (edge_q && armed_q) begin
          armed_d = 1'b0;
          wcnt_d  = width_q;
          if (delay_q == '0) begin
            sst_d = S_PULSE;
          end else begin
            sst_d  = S_DELAY;
            dcnt_d = delay_q - DELAY_W'(1);
          end
        end
      end
      S_DELAY: begin
        if (dcnt_q == '0) begin
          sst_d = S_PULSE;
        end else begin
          dcnt_d = dcnt_q - DELAY_W'(1);
        end
      end
      S_PULSE: begin
        if (wcnt_q <= WIDTH_W'(1)) begin
          sst_d    = S_IDLE;
          done_d   = 1'b1;
          sticky_d = 1'b1;
`ifdef TRIG_SEQ_AUTOREARM_EN
          armed_d  = 1'b1;
`else
          armed_d  = armed_q;
`endif
        end else begin
          wcnt_d = wcnt_q - WIDTH_W'(1);
        end
      end
      default: sst_d = S_IDLE;
    endcase
    if (arm_cmd) begin
      armed_d  = 1'b1;
      sticky_d = 1'b0;
    end
    if (cancel_cmd) begin
      armed_d  = 1'b0;
      sst_d    = S_IDLE;
      done_d   = 1'b0;
      sticky_d = sticky_q;
    end
    trig_d = (sst_d == S_PULSE);
    busy_d = (sst_d != S_IDLE);
  end

  always_ff @(posedge i_clk_hs2 or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pst_q    <= P_IDLE;
      sst_q    <= S_IDLE;
      delay_q  <= '0;
      width_q  <= WIDTH_W'(1);
      dcnt_q   <= '0;
      wcnt_q   <= WIDTH_W'(1);
      armed_q  <= 1'b0;
      sticky_q <= 1'b0;
      done_q   <= 1'b0;
      trig_q   <= 1'b0;
      busy_q   <= 1'b0;
      rdy_q    <= 1'b0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      edge_q   <= 1'b0;
    end else begin
      pst_q    <= pst_d;
      sst_q    <= sst_d;
      delay_q  <= delay_d;
      width_q  <= width_d;
      dcnt_q   <= dcnt_d;
      wcnt_q   <= wcnt_d;
      armed_q  <= armed_d;
      sticky_q <= sticky_d;
      done_q   <= done_d;
      trig_q   <= trig_d;
      busy_q   <= busy_d;
      rdy_q    <= 1'b1;
      s1_q     <= i_start;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      edge_q   <= s2_q & ~s3_q;
    end
  end

  assign o_cmd_ready = rdy_q;
  assign o_trigger   = trig_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_led       = {armed_q, busy_q, sticky_q};

endmodule

// File: tb/tb_trig_sequencer.sv
// tb_trig_sequencer: directed bench for trig_sequencer.
// Edge k counts from the first clock edge that samples i_start=1.
module tb_trig_sequencer;

`ifdef TRIG_SEQ_AUTOREARM_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic       start;
  logic       trig;
  logic       busy;
  logic       done;
  logic [2:0] led;

  int n_chk;
  int n_fail;

  int   rise, wid, dn, dn_at;
  logic b2, b3;

  always #5 clk = ~clk;

  trig_sequencer dut (
    .i_clk_hs2   (clk),
    .i_reset_n   (rst_n),
    .i_cmd_valid (cmd_valid),
    .i_cmd_data  (cmd_data),
    .o_cmd_ready (cmd_ready),
    .i_start     (start),
    .o_trigger   (trig),
    .o_busy      (busy),
    .o_done      (done),
    .o_led       (led)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    cmd_valid = 1'b1;
    cmd_data  = b;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic settle();
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic observe(input int n, output int r, output int w,
                         output int d, output int da,
                         output logic e2, output logic e3);
    r = -1; w = 0; d = 0; da = -1; e2 = 1'b0; e3 = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (trig) begin
        if (r < 0) r = k;
        w++;
      end
      if (done) begin
        d++;
        if (da < 0) da = k;
      end
      if (k == 2) e2 = busy;
      if (k == 3) e3 = busy;
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_data = 8'h00; start = 1'b0;
    #3;
    chk("rst_trig", int'(trig), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_led", int'(led), 0);
    chk("rst_rdy", int'(cmd_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rdy_pre_edge", int'(cmd_ready), 0);
    @(posedge clk);
    #1;
    chk("rdy_post_edge", int'(cmd_ready), 1);

    // D=5 W=3
    send(8'h44); send(8'h00); send(8'h05);
    send(8'h57); send(8'h03); send(8'h41);
    chk("t1_led_armed", int'(led), 3'b100);
    start = 1'b1;
    observe(16, rise, wid, dn, dn_at, b2, b3);
    chk("t1_busy_e2", int'(b2), 0);
    chk("t1_busy_e3", int'(b3), 1);
    chk("t1_rise", rise, 8);
    chk("t1_width", wid, 3);
    chk("t1_dones", dn, 1);
    chk("t1_done_at", dn_at, 11);
    chk("t1_led_after", int'(led), AR ? 3'b101 : 3'b001);
    settle();

    // D=0 W=0 -> stored as 1
    send(8'h44); send(8'h00); send(8'h00);
    send(8'h57); send(8'h00); send(8'h41);
    start = 1'b1;
    observe(10, rise, wid, dn, dn_at, b2, b3);
    chk("t2_rise", rise, 3);
    chk("t2_width", wid, 1);
    chk("t2_dones", dn, 1);
    settle();

    // start while disarmed
    send(8'h43);
    start = 1'b1;
    observe(10, rise, wid, dn, dn_at, b2, b3);
    chk("t4_noarm_width", wid, 0);
    chk("t4_noarm_dones", dn, 0);
    settle();

    // second start edge during S_PULSE
    send(8'h44); send(8'h00); send(8'h00);
    send(8'h57); send(8'h0a); send(8'h41);
    start = 1'b1;
    fork
      observe(30, rise, wid, dn, dn_at, b2, b3);
      begin
        repeat (6) @(posedge clk);
        #1; start = 1'b0;
        repeat (2) @(posedge clk);
        #1; start = 1'b1;
      end
    join
    chk("t4_busy_rise", rise, 3);
    chk("t4_busy_width", wid, 10);
    chk("t4_busy_dones", dn, 1);
    settle();

    // start after completion, no new 'A'
    start = 1'b1;
    observe(16, rise, wid, dn, dn_at, b2, b3);
    chk("t4_rerun_width", wid, AR ? 10 : 0);
    chk("t4_rerun_dones", dn, AR ? 1 : 0);
    settle();
    send(8'h43);

    // cancel during S_DELAY with D=0x0100
    send(8'h44); send(8'h01); send(8'h00);
    send(8'h57); send(8'h03); send(8'h41);
    start = 1'b1;
    fork
      observe(256 + 30, rise, wid, dn, dn_at, b2, b3);
      begin
        repeat (20) @(posedge clk);
        #1;
        chk("t3_busy_before", int'(busy), 1);
        send(8'h43);
        chk("t3_busy_after", int'(busy), 0);
        chk("t3_led_after", int'(led), 3'b000);
      end
    join
    chk("t3_width", wid, 0);
    chk("t3_dones", dn, 0);
    settle();

    // literal data bytes, ignored junk, W write mid-delay
    send(8'h44); send(8'h41); send(8'h57); send(8'h99);
    send(8'h57); send(8'h03); send(8'h41);
    start = 1'b1;
    fork
      observe(16727 + 13, rise, wid, dn, dn_at, b2, b3);
      begin
        repeat (20) @(posedge clk);
        #1;
        send(8'h57); send(8'h10);
      end
    join
    chk("t5_rise", rise, 16730);
    chk("t5_width_kept", wid, 3);
    chk("t5_dones", dn, 1);
    settle();
    send(8'h44); send(8'h00); send(8'h02); send(8'h41);
    start = 1'b1;
    observe(30, rise, wid, dn, dn_at, b2, b3);
    chk("t5_next_rise", rise, 5);
    chk("t5_next_width", wid, 16);
    settle();

    // async reset mid-pulse
    send(8'h44); send(8'h00); send(8'h00);
    send(8'h57); send(8'h14); send(8'h41);
    start = 1'b1;
    repeat (8) @(posedge clk);
    #3;
    chk("t6_trig_pre", int'(trig), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_trig_async", int'(trig), 0);
    chk("t6_led_async", int'(led), 0);
    chk("t6_busy_async", int'(busy), 0);
    chk("t6_rdy_async", int'(cmd_ready), 0);
    #10;
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_trig_rel", int'(trig), 0);
    chk("t6_busy_rel", int'(busy), 0);
    chk("t6_done_rel", int'(done), 0);
    chk("t6_led_rel", int'(led), 0);
    chk("t6_rdy_rel", int'(cmd_ready), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
